// File: rtl/boundary_scan_chain.sv
// -----------------------------------------------------------------------------
// boundary_scan_chain
//
// Boundary-scan data register in the IEEE 1149.1 style. It wraps a 16-bit
// adder/selector core. Input cells sit between the system pins and the core
// inputs. Output cells sit between the core outputs and the system pins. All
// cells form one serial chain of 3*N+3 bits, running from TDI to TDO.
//
// Cell index order along the chain, starting at TDI:
//   a[0..N-1]   : 0      .. N-1
//   b[0..N-1]   : N      .. 2N-1
//   cin         : 2N
//   sel         : 2N+1
//   sum[0..N-1] : 2N+2   .. 3N+1
//   co          : 3N+2   (last cell, drives TDO)
//
// Each cell has a shift/capture flop (S) and an update flop (U).
//
// Ports:
//   ClockDR          in   DR clock, all state changes on its rising edge
//   Reset            in   synchronous active-high reset of all S and U flops
//   TDI              in   serial scan input
//   ShiftDR          in   1 = shift the chain, 0 = capture the parallel inputs
//   UpdateDR         in   1 = load U from S (pre-edge S value)
//   Mode             in   0 = pass-through, 1 = parallel outputs driven from U
//   sys_pin_a/b      in   system-side operands (N bits)
//   sys_pin_cin/sel  in   system-side carry-in / select
//   module_pin_sum   in   core-side sum (N bits)
//   module_pin_co    in   core-side carry-out
//   module_pin_a/b   out  operands to the core (N bits)
//   module_pin_cin   out  carry-in to the core
//   module_pin_sel   out  select to the core
//   sys_pin_sum      out  sum to the system (N bits)
//   sys_pin_co       out  carry-out to the system
//   TDO              out  serial scan output
//
// Optional feature, macro BSC_TDO_NEGEDGE_EN:
//   When defined, TDO is retimed through a falling-edge flop. That flop is
//   cleared by Reset on the falling edge.
//   When undefined, TDO is the S flop of the last cell.
// -----------------------------------------------------------------------------
module boundary_scan_chain #(
   parameter int N = 16
) (
   input  logic         ClockDR,
   input  logic         Reset,
   input  logic         TDI,
   input  logic         ShiftDR,
   input  logic         UpdateDR,
   input  logic         Mode,
   input  logic [N-1:0] sys_pin_a,
   input  logic [N-1:0] sys_pin_b,
   input  logic         sys_pin_cin,
   input  logic         sys_pin_sel,
   input  logic [N-1:0] module_pin_sum,
   input  logic         module_pin_co,
   output logic [N-1:0] module_pin_a,
   output logic [N-1:0] module_pin_b,
   output logic         module_pin_cin,
   output logic         module_pin_sel,
   output logic [N-1:0] sys_pin_sum,
   output logic         sys_pin_co,
   output logic         TDO
);

   localparam int L       = 3*N + 3;
   localparam int B_LO    = N;
   localparam int CIN_IDX = 2*N;
   localparam int SEL_IDX = 2*N + 1;
   localparam int SUM_LO  = 2*N + 2;
   localparam int CO_IDX  = 3*N + 2;

   logic [L-1:0] r_s;        // shift/capture stage, bit i = cell i
   logic [L-1:0] r_u;        // update stage
   logic [L-1:0] w_par_in;   // parallel capture value of every cell

   // The concatenation puts a[0] at bit 0, so bit i is the capture value of cell i.
   assign w_par_in = {module_pin_co, module_pin_sum, sys_pin_sel, sys_pin_cin,
                      sys_pin_b, sys_pin_a};

   // NOTE: these are non-blocking assignments, so r_u samples the value r_s
   // had before the edge. That holds even when ShiftDR and UpdateDR are both
   // high on the same edge.
   always_ff @(posedge ClockDR) begin
      if (Reset) begin
         r_s <= '0;
         r_u <= '0;
      end else begin
         if (ShiftDR)
            r_s <= {r_s[L-2:0], TDI};
         else
            r_s <= w_par_in;
         if (UpdateDR)
            r_u <= r_s;
      end
   end

   // Parallel-side muxes. These are purely combinational, so Mode=0 gives
   // zero-latency pass-through whatever the scan logic is doing.
   assign module_pin_a   = Mode ? r_u[N-1:0]              : sys_pin_a;
   assign module_pin_b   = Mode ? r_u[B_LO +: N]          : sys_pin_b;
   assign module_pin_cin = Mode ? r_u[CIN_IDX]            : sys_pin_cin;
   assign module_pin_sel = Mode ? r_u[SEL_IDX]            : sys_pin_sel;
   assign sys_pin_sum    = Mode ? r_u[SUM_LO +: N]        : module_pin_sum;
   assign sys_pin_co     = Mode ? r_u[CO_IDX]             : module_pin_co;

`ifdef BSC_TDO_NEGEDGE_EN
   // TDO changes half a cycle after the shift edge, as 1149.1 TDO timing
   // expects. Reset is sampled on the falling edge.
   logic r_tdo;

   always_ff @(negedge ClockDR) begin
      if (Reset)
         r_tdo <= 1'b0;
      else
         r_tdo <= r_s[CO_IDX];
   end

   assign TDO = r_tdo;
`else
   assign TDO = r_s[CO_IDX];
`endif

endmodule

// File: tb/tb_boundary_scan_chain.sv
// -----------------------------------------------------------------------------
// tb_boundary_scan_chain
//
// Self-checking bench for boundary_scan_chain.
//
// The reference model holds the chain as two queues of cell bits, S and U.
// Index i is cell i. A shift pushes TDI in at the front and drops the last
// cell. A capture rebuilds S from the pin values, one field at a time.
//
// Outputs are sampled just after the falling edge. That point is valid with
// or without the retimed-TDO option.
// -----------------------------------------------------------------------------
module tb_boundary_scan_chain;

   localparam int N = 16;
   localparam int L = 3*N + 3;

   logic         ClockDR = 1'b0;
   logic         Reset, TDI, ShiftDR, UpdateDR, Mode;
   logic [N-1:0] sys_pin_a, sys_pin_b, module_pin_sum;
   logic         sys_pin_cin, sys_pin_sel, module_pin_co;
   logic [N-1:0] module_pin_a, module_pin_b, sys_pin_sum;
   logic         module_pin_cin, module_pin_sel, sys_pin_co, TDO;

   int checks   = 0;
   int failures = 0;

   bit q_s[$];
   bit q_u[$];
   bit exp_seq[$];

   boundary_scan_chain #(.N(N)) dut (
      .ClockDR       (ClockDR),
      .Reset         (Reset),
      .TDI           (TDI),
      .ShiftDR       (ShiftDR),
      .UpdateDR      (UpdateDR),
      .Mode          (Mode),
      .sys_pin_a     (sys_pin_a),
      .sys_pin_b     (sys_pin_b),
      .sys_pin_cin   (sys_pin_cin),
      .sys_pin_sel   (sys_pin_sel),
      .module_pin_sum(module_pin_sum),
      .module_pin_co (module_pin_co),
      .module_pin_a  (module_pin_a),
      .module_pin_b  (module_pin_b),
      .module_pin_cin(module_pin_cin),
      .module_pin_sel(module_pin_sel),
      .sys_pin_sum   (sys_pin_sum),
      .sys_pin_co    (sys_pin_co),
      .TDO           (TDO)
   );

   always #5 ClockDR = ~ClockDR;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_clear();
      q_s.delete();
      q_u.delete();
      for (int i = 0; i < L; i++) begin
         q_s.push_back(1'b0);
         q_u.push_back(1'b0);
      end
   endtask

   task automatic model_edge();
      if (Reset) begin
         model_clear();
      end else begin
         if (UpdateDR) q_u = q_s;
         if (ShiftDR) begin
            q_s.push_front(TDI);
            void'(q_s.pop_back());
         end else begin
            for (int j = 0; j < N; j++) begin
               q_s[j]          = sys_pin_a[j];
               q_s[N + j]      = sys_pin_b[j];
               q_s[2*N + 2 + j] = module_pin_sum[j];
            end
            q_s[2*N]     = sys_pin_cin;
            q_s[2*N + 1] = sys_pin_sel;
            q_s[3*N + 2] = module_pin_co;
         end
      end
   endtask

   function automatic logic [N-1:0] u_field(input int base);
      logic [N-1:0] r;
      for (int j = 0; j < N; j++) r[j] = q_u[base + j];
      return r;
   endfunction

   // One rising edge. The model steps alongside the DUT, then the bench
   // settles past the falling edge before any sampling.
   task automatic tick();
      @(posedge ClockDR);
      model_edge();
      @(negedge ClockDR);
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".a"},   32'(module_pin_a),   32'(Mode ? u_field(0)       : sys_pin_a));
      check({tag, ".b"},   32'(module_pin_b),   32'(Mode ? u_field(N)       : sys_pin_b));
      check({tag, ".cin"}, 32'(module_pin_cin), 32'(Mode ? q_u[2*N]       : sys_pin_cin));
      check({tag, ".sel"}, 32'(module_pin_sel), 32'(Mode ? q_u[2*N + 1]   : sys_pin_sel));
      check({tag, ".sum"}, 32'(sys_pin_sum),    32'(Mode ? u_field(2*N + 2) : module_pin_sum));
      check({tag, ".co"},  32'(sys_pin_co),     32'(Mode ? q_u[3*N + 2]   : module_pin_co));
      check({tag, ".tdo"}, 32'(TDO),            32'(q_s[L-1]));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      model_clear();
      Reset = 1'b1; TDI = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0; Mode = 1'b1;
      sys_pin_a = '0; sys_pin_b = '0; sys_pin_cin = 1'b0; sys_pin_sel = 1'b0;
      module_pin_sum = '0; module_pin_co = 1'b0;

      // Reset with Mode=1: every driven output and TDO read zero.
      sys_pin_a = 16'h1234; module_pin_sum = 16'h5678; module_pin_co = 1'b1;
      tick();
      check("rst.a",   32'(module_pin_a),   32'h0);
      check("rst.b",   32'(module_pin_b),   32'h0);
      check("rst.cin", 32'(module_pin_cin), 32'h0);
      check("rst.sel", 32'(module_pin_sel), 32'h0);
      check("rst.sum", 32'(sys_pin_sum),    32'h0);
      check("rst.co",  32'(sys_pin_co),     32'h0);
      check("rst.tdo", 32'(TDO),            32'h0);
      Reset = 1'b0;

      // Transparency, including while the chain is shifting.
      Mode = 1'b0;
      sys_pin_a = 16'hFFFF; sys_pin_b = 16'h0000; sys_pin_cin = 1'b1; sys_pin_sel = 1'b1;
      module_pin_sum = 16'hFF00; module_pin_co = 1'b1;
      #1;
      check("xp.a",   32'(module_pin_a),   32'hFFFF);
      check("xp.b",   32'(module_pin_b),   32'h0000);
      check("xp.cin", 32'(module_pin_cin), 32'h1);
      check("xp.sel", 32'(module_pin_sel), 32'h1);
      check("xp.sum", 32'(sys_pin_sum),    32'hFF00);
      check("xp.co",  32'(sys_pin_co),     32'h1);
      ShiftDR = 1'b1;
      for (int k = 0; k < 5; k++) begin
         TDI = 1'($urandom);
         tick();
         check("xp_shift.a",   32'(module_pin_a), 32'hFFFF);
         check("xp_shift.sum", 32'(sys_pin_sum),  32'hFF00);
      end

      // Capture, then shift out. The expected TDO order is built from the pin values.
      exp_seq.delete();
      exp_seq.push_back(1'b1);                                  // co
      for (int k = 0; k < 8; k++)  exp_seq.push_back(1'b1);     // sum15..8
      for (int k = 0; k < 8; k++)  exp_seq.push_back(1'b0);     // sum7..0
      exp_seq.push_back(1'b1);                                  // sel
      exp_seq.push_back(1'b1);                                  // cin
      for (int k = 0; k < 16; k++) exp_seq.push_back(1'b0);     // b
      for (int k = 0; k < 16; k++) exp_seq.push_back(1'b1);     // a
      ShiftDR = 1'b0;
      tick();
      check("cap.tdo0", 32'(TDO), 32'(exp_seq[0]));
      ShiftDR = 1'b1;
      TDI = 1'b0;
      for (int k = 1; k < L; k++) begin
         tick();
         check($sformatf("cap.tdo%0d", k), 32'(TDO), 32'(exp_seq[k]));
      end

      // Shift in 0,1,0,1,... and then update with Mode=1.
      for (int k = 0; k < L; k++) begin
         TDI = 1'(k % 2);
         tick();
      end
      ShiftDR = 1'b0; UpdateDR = 1'b1; Mode = 1'b1;
      tick();
      check("upd.a",   32'(module_pin_a),   32'hAAAA);
      check("upd.b",   32'(module_pin_b),   32'hAAAA);
      check("upd.cin", 32'(module_pin_cin), 32'h0);
      check("upd.sel", 32'(module_pin_sel), 32'h1);
      check("upd.sum", 32'(sys_pin_sum),    32'hAAAA);
      check("upd.co",  32'(sys_pin_co),     32'h0);
      check_all("upd");

      // Update hold: further shifting with UpdateDR=0 leaves U unchanged.
      UpdateDR = 1'b0; ShiftDR = 1'b1;
      for (int k = 0; k < 10; k++) begin
         TDI = 1'($urandom);
         tick();
      end
      check("hold.a",   32'(module_pin_a),   32'hAAAA);
      check("hold.b",   32'(module_pin_b),   32'hAAAA);
      check("hold.cin", 32'(module_pin_cin), 32'h0);
      check("hold.sel", 32'(module_pin_sel), 32'h1);
      check("hold.sum", 32'(sys_pin_sum),    32'hAAAA);
      check("hold.co",  32'(sys_pin_co),     32'h0);
      Mode = 1'b0;
      #1;
      check("hold_pt.a",   32'(module_pin_a), 32'hFFFF);
      check("hold_pt.sum", 32'(sys_pin_sum),  32'hFF00);

      // Simultaneous ShiftDR and UpdateDR: U takes the pre-shift S.
      Mode = 1'b1;
      for (int k = 0; k < L; k++) begin
         TDI = 1'((k + 1) % 2);
         tick();
      end
      UpdateDR = 1'b1; TDI = 1'b0;
      tick();
      check("sim.a",   32'(module_pin_a),   32'h5555);
      check("sim.cin", 32'(module_pin_cin), 32'h1);
      check("sim.sel", 32'(module_pin_sel), 32'h0);
      check("sim.sum", 32'(sys_pin_sum),    32'h5555);
      check("sim.co",  32'(sys_pin_co),     32'h1);
      check("sim.tdo", 32'(TDO),            32'h0);
      check_all("sim");

      // A reset in the middle of a shift clears both stages.
      UpdateDR = 1'b0;
      for (int k = 0; k < 7; k++) begin
         TDI = 1'b1;
         tick();
      end
      Reset = 1'b1;
      tick();
      check("mrst.a",   32'(module_pin_a), 32'h0);
      check("mrst.co",  32'(sys_pin_co),   32'h0);
      check("mrst.tdo", 32'(TDO),          32'h0);
      Reset = 1'b0;
      for (int k = 0; k < L; k++) begin
         TDI = 1'b0;
         tick();
         check("mrst_flush.tdo", 32'(TDO), 32'h0);
      end

      // Random operation compared against the model on every edge.
      for (int k = 0; k < 400; k++) begin
         Reset          = ($urandom_range(0, 49) == 0);
         ShiftDR        = 1'($urandom);
         UpdateDR       = ($urandom_range(0, 3) == 0);
         Mode           = 1'($urandom);
         TDI            = 1'($urandom);
         sys_pin_a      = 16'($urandom);
         sys_pin_b      = 16'($urandom);
         sys_pin_cin    = 1'($urandom);
         sys_pin_sel    = 1'($urandom);
         module_pin_sum = 16'($urandom);
         module_pin_co  = 1'($urandom);
         tick();
         check_all("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/boundary_scan_chain.md
Name: boundary_scan_chain

Overview:
- IEEE 1149.1-style boundary-scan data register wrapping a 16-bit adder/selector core.
- Input cells sit between system pins (a, b, cin, sel) and the core inputs; output cells sit between the core outputs (sum, co) and the system pins.
- Cells form one 51-bit serial chain from TDI to TDO, driven by TAP-controller decodes (ShiftDR, UpdateDR, Mode).

Parameters:
- N, 16, width of the a, b and sum buses. Chain length is 3*N+3.

Ports:
- ClockDR  input  1  DR clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- TDI  input  1  serial scan in
- ShiftDR  input  1  1 = shift chain, 0 = capture parallel inputs
- UpdateDR  input  1  1 = load update stage from shift stage
- Mode  input  1  0 = functional pass-through, 1 = drive pins from update stage
- sys_pin_a  input  N  system-side operand a
- sys_pin_b  input  N  system-side operand b
- sys_pin_cin  input  1  system-side carry in
- sys_pin_sel  input  1  system-side select
- module_pin_sum  input  N  core-side sum
- module_pin_co  input  1  core-side carry out
- module_pin_a  output  N  to core
- module_pin_b  output  N  to core
- module_pin_cin  output  1  to core
- module_pin_sel  output  1  to core
- sys_pin_sum  output  N  to system
- sys_pin_co  output  1  to system
- TDO  output  1  serial scan out

Behaviour:
- Chain order from TDI, cell index 0..50:
  - a[0..N-1] = 0..15
  - b[0..N-1] = 16..31
  - cin = 32
  - sel = 33
  - sum[0..N-1] = 34..49
  - co = 50
- TDO = shift flop of cell 50 (registered, no combinational path from TDI).
- Each cell has a shift/capture flop (S) and an update flop (U).
- Per rising ClockDR edge, priority order:
  - Reset=1: all S and U cleared to 0.
  - Otherwise, S:
    - ShiftDR=1: S[i] <= S[i-1], with S[0] <= TDI.
    - ShiftDR=0: S <= parallel input of its cell (sys_pin_* for input cells, module_pin_* for output cells).
  - Otherwise, U: UpdateDR=1 gives U <= S (pre-edge value of S); UpdateDR=0 holds U.
- ShiftDR and UpdateDR both high on the same edge: U loads the old S, and S shifts.
- Parallel outputs are combinational muxes, per cell:
  - Input cells: module_pin_x = Mode ? U : sys_pin_x.
  - Output cells: sys_pin_x = Mode ? U : module_pin_x.
- Mode=0: fully transparent, zero latency, regardless of scan activity.
- Serial latency: a TDI bit reaches TDO after 51 shift edges. After a capture edge, TDO shows the captured co immediately.
- Reset values: TDO=0; with Mode=1 all parallel outputs 0; with Mode=0 outputs follow their pins.
- Reset asserted mid-shift aborts the operation. The chain restarts from all-zero.

Optional Feature:
- Macro: BSC_TDO_NEGEDGE_EN.
- Defined: TDO is retimed through an extra flop on the falling edge of ClockDR, per 1149.1 TDO timing. It is reset to 0 by the synchronous Reset on that falling edge, and TDO changes half a cycle after the shift edge.
- Undefined: TDO is cell 50's S flop directly.

Test Plan:
- Transparency: Mode=0, a=FFFF, b=0000, cin=1, sel=1, sum=FF00, co=1 -> module_pin_a=FFFF, module_pin_b=0000, module_pin_cin=1, module_pin_sel=1, sys_pin_sum=FF00, sys_pin_co=1, unchanged while shifting.
- Reset: Reset=1 for one edge, Mode=1 -> all module_pin_*, sys_pin_sum, sys_pin_co and TDO = 0.
- Capture/shift-out:
  - Stimulus: same pins as the transparency case, one ShiftDR=0 edge, then ShiftDR=1 for 50 edges.
  - TDO order: 1 (co), eight 1s (sum15..8), eight 0s, 1 (sel), 1 (cin), sixteen 0s (b), sixteen 1s (a).
- Shift-in/update:
  - Stimulus: shift 51 bits 0,1,0,1,... (first bit 0), then one edge with ShiftDR=0, UpdateDR=1, Mode=1.
  - Response: module_pin_a=AAAA, module_pin_b=AAAA, cin=0, sel=1, sys_pin_sum=AAAA, sys_pin_co=0.
- Update hold: after the shift-in/update case, UpdateDR=0 with further shifting -> outputs stay AAAA/0/1/AAAA/0; toggling Mode to 0 returns pass-through.
- Simultaneous ShiftDR=1 and UpdateDR=1 on one edge -> U receives pre-shift S contents, and the chain still advances one bit.
